// File: rtl/core_types_pkg.sv
// Shared core types for the data-memory responder: FSM states, load/store func3
// encodings, the captured request record and the MMIO window base.
package core_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef struct packed {
        logic        write;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam logic [31:0] DMEM_MMIO_BASE = 32'hFFFF_FFF0;

    // 011, 110 and 111 have no RV32I load/store meaning.
    function automatic logic func3_illegal(input logic [2:0] f);
        return !(f inside {LS_B, LS_H, LS_W, LS_BU, LS_HU});
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores: lane mask, replicated store data,
// shifted and extended load data, and the alignment check.
module dmem_lane_align
    import core_types_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_mask,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_ext,
    output logic        o_misalign
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift     = i_rword >> {i_addr_lo, 3'b000};
        o_byte_mask = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata_ext = w_shift;
        o_misalign  = 1'b0;
        case (i_func3[1:0])
            2'b00: begin
                o_byte_mask = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata_ext = i_func3[2] ? {24'h0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            end
            2'b01: begin
                o_byte_mask = 4'b0011 << i_addr_lo;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata_ext = i_func3[2] ? {16'h0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
                o_misalign  = i_addr_lo[0];
            end
            default: begin
                o_misalign  = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles, commits
// to the word RAM and holds the response until taken. Optional MMIO: DMEM_MMIO_EN.
module dmem_responder
    import core_types_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    dmem_state_t        r_state;
    dmem_state_t        w_next;
    dmem_req_t          r_req;
    logic [4:0]         r_wait;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept;
    logic               w_commit;
    logic               w_cap_ram;
    logic [ADDR_W-3:0]  w_word_idx;
    logic [31:0]        w_raw_word;
    logic [2:0]         w_la_func3;
    logic [1:0]         w_la_addr;
    logic [31:0]        w_la_wdata;
    logic [3:0]         w_byte_mask;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rdata_ext;
    logic               w_misalign;
    logic               w_req_unmapped;
    logic               w_mmio_bad;
    logic               w_req_err;

    assign w_accept   = req_valid && req_ready;
    assign w_commit   = (r_state == BUSY) && (r_wait == 5'd1);
    assign w_cap_ram  = (r_req.addr[31:ADDR_W] == '0);
    assign w_word_idx = r_req.addr[ADDR_W-1:2];

    // In IDLE the aligner checks the incoming request; afterwards it serves the captured one.
    assign w_la_func3 = (r_state == IDLE) ? req_func3      : r_req.func3;
    assign w_la_addr  = (r_state == IDLE) ? req_addr[1:0]  : r_req.addr[1:0];
    assign w_la_wdata = (r_state == IDLE) ? req_wdata      : r_req.wdata;

    dmem_lane_align u_align (
        .i_func3     (w_la_func3),
        .i_addr_lo   (w_la_addr),
        .i_wdata     (w_la_wdata),
        .i_rword     (w_raw_word),
        .o_byte_mask (w_byte_mask),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext),
        .o_misalign  (w_misalign)
    );

`ifdef DMEM_MMIO_EN
    logic [31:0] r_cycles;
    logic [31:0] r_scratch;
    logic        w_req_mmio;

    assign w_req_mmio     = (req_addr[31:4] == DMEM_MMIO_BASE[31:4]);
    assign w_mmio_bad     = w_req_mmio && ((req_func3 != LS_W) ||
                            !((req_addr[3:0] == 4'h0) || (req_addr[3:0] == 4'h4)));
    assign w_req_unmapped = (req_addr[31:ADDR_W] != '0) && !w_req_mmio;
    assign w_raw_word     = w_cap_ram ? r_mem[w_word_idx]
                          : (r_req.addr[2] ? r_scratch : r_cycles);

    always_ff @(posedge Clock or posedge nReset) begin
        if (nReset) begin
            r_cycles  <= '0;
            r_scratch <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_commit && r_req.write && !w_cap_ram && r_req.addr[2])
                r_scratch <= w_wdata_rep;
        end
    end
`else
    assign w_mmio_bad     = 1'b0;
    assign w_req_unmapped = (req_addr[31:ADDR_W] != '0);
    assign w_raw_word     = r_mem[w_word_idx];
`endif

    assign w_req_err = func3_illegal(req_func3) || w_misalign || w_req_unmapped || w_mmio_bad;

    always_ff @(posedge Clock or posedge nReset) begin
        if (nReset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_req_err ? RESP : BUSY;
            BUSY: if (r_wait == 5'd1) w_next = RESP;
            RESP: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        rsp_rdata = r_rsp_rdata;
        rsp_err   = r_rsp_err;
    end

    // Counter is loaded one above WAIT_STATES so the commit edge lands WAIT_STATES+1 after accept.
    always_ff @(posedge Clock or posedge nReset) begin
        if (nReset) begin
            r_req       <= '0;
            r_wait      <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_req       <= '{write: req_write, func3: req_func3, addr: req_addr, wdata: req_wdata};
            r_wait      <= 5'(WAIT_STATES + 1);
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_req_err;
        end else if (r_state == BUSY) begin
            r_wait <= r_wait - 5'd1;
            if (w_commit)
                r_rsp_rdata <= r_req.write ? 32'h0 : w_rdata_ext;
        end else if ((r_state == RESP) && rsp_ready) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_commit && r_req.write && w_cap_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_mask[i])
                    r_mem[w_word_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=1 instance and a WAIT_STATES=0
// instance share the request fields; expectations are hand-computed constants.
module tb_dmem_responder;

   logic        Clock = 1'b0;
   logic        nReset;
   logic        reqValid, rspReady, useFast;
   logic        reqWrite;
   logic [2:0]  reqFunc3;
   logic [31:0] reqAddr, reqWdata;

   logic        reqReady1, rspValid1, rspErr1;
   logic        reqReady0, rspValid0, rspErr0;
   logic [31:0] rspRdata1, rspRdata0;

   logic        curReqReady, curRspValid, curRspErr;
   logic [31:0] curRspRdata;

   int errors = 0;
   int checks = 0;

   always #5 Clock = ~Clock;

   assign curReqReady = useFast ? reqReady0 : reqReady1;
   assign curRspValid = useFast ? rspValid0 : rspValid1;
   assign curRspErr   = useFast ? rspErr0   : rspErr1;
   assign curRspRdata = useFast ? rspRdata0 : rspRdata1;

   dmem_responder #(.ADDR_W(12), .WAIT_STATES(1)) dut (
      .Clock     (Clock),
      .nReset    (nReset),
      .req_valid (reqValid && !useFast),
      .req_ready (reqReady1),
      .req_write (reqWrite),
      .req_func3 (reqFunc3),
      .req_addr  (reqAddr),
      .req_wdata (reqWdata),
      .rsp_valid (rspValid1),
      .rsp_ready (rspReady && !useFast),
      .rsp_rdata (rspRdata1),
      .rsp_err   (rspErr1)
   );

   dmem_responder #(.ADDR_W(12), .WAIT_STATES(0)) dutFast (
      .Clock     (Clock),
      .nReset    (nReset),
      .req_valid (reqValid && useFast),
      .req_ready (reqReady0),
      .req_write (reqWrite),
      .req_func3 (reqFunc3),
      .req_addr  (reqAddr),
      .req_wdata (reqWdata),
      .rsp_valid (rspValid0),
      .rsp_ready (rspReady && useFast),
      .rsp_rdata (rspRdata0),
      .rsp_err   (rspErr0)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Present a request (called #1 after a rising edge) and return the accept time.
   task automatic sendReq(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output time acceptTime);
      int n = 0;
      reqWrite = wr; reqFunc3 = f3; reqAddr = addr; reqWdata = wdata; reqValid = 1'b1;
      while (!curReqReady && n < 20) begin
         @(posedge Clock); #1; n++;
      end
      if (!curReqReady) checkOutput("accept_timeout", {31'h0, curReqReady}, 32'h1);
      @(posedge Clock);
      acceptTime = $time;
      #1;
      reqValid = 1'b0;
      reqWrite = 1'b1; reqFunc3 = 3'b111; reqAddr = 32'hFFFF_FFFF; reqWdata = 32'h5555_5555;
   endtask

   task automatic waitRsp(output int lat, output logic [31:0] rdata, output logic err);
      lat = 0;
      while (!curRspValid && lat < 40) begin
         @(posedge Clock); #1; lat++;
      end
      if (!curRspValid) checkOutput("rsp_timeout", {31'h0, curRspValid}, 32'h1);
      rdata = curRspRdata;
      err   = curRspErr;
   endtask

   task automatic ackRsp();
      rspReady = 1'b1;
      @(posedge Clock); #1;
      rspReady = 1'b0;
   endtask

   task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output int lat,
                                output logic [31:0] rdata, output logic err);
      time t;
      sendReq(wr, f3, addr, wdata, t);
      waitRsp(lat, rdata, err);
      ackRsp();
   endtask

   // Run one transaction and compare data and error flag (and latency when expLat >= 0).
   task automatic runCheck(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expData, input logic expErr, input int expLat);
      int lat;
      logic [31:0] rd;
      logic er;
      applyStimulus(wr, f3, addr, wdata, lat, rd, er);
      checkOutput({tag, "_rdata"}, rd, expData);
      checkOutput({tag, "_err"}, {31'h0, er}, {31'h0, expErr});
      if (expLat >= 0) checkOutput({tag, "_lat"}, lat, expLat);
   endtask

   initial begin
      time t1, t2;
      int lat;
      logic [31:0] rd, rdA, rdB;
      logic er;

      nReset = 1'b1; reqValid = 1'b0; rspReady = 1'b0; useFast = 1'b0;
      reqWrite = 1'b0; reqFunc3 = 3'b010; reqAddr = '0; reqWdata = '0;
      #11;
      checkOutput("reset_rsp_valid", {31'h0, rspValid1}, 32'h0);
      checkOutput("reset_req_ready", {31'h0, reqReady1}, 32'h1);
      checkOutput("reset_rdata",     rspRdata1, 32'h0);
      checkOutput("reset_err",       {31'h0, rspErr1}, 32'h0);
      @(posedge Clock); #1;
      nReset = 1'b0;
      @(posedge Clock); #1;

      runCheck("sw_dead",  1'b1, 3'b010, 32'h010, 32'hDEAD_BEEF, 32'h0,         1'b0, 2);
      runCheck("lw_dead",  1'b0, 3'b010, 32'h010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2);
      runCheck("sb_80",    1'b1, 3'b000, 32'h013, 32'h0000_0080, 32'h0,         1'b0, 2);
      runCheck("lb_13",    1'b0, 3'b000, 32'h013, 32'h0,         32'hFFFF_FF80, 1'b0, 2);
      runCheck("lbu_13",   1'b0, 3'b100, 32'h013, 32'h0,         32'h0000_0080, 1'b0, -1);
      runCheck("lw_merge", 1'b0, 3'b010, 32'h010, 32'h0,         32'h80AD_BEEF, 1'b0, -1);
      runCheck("lh_12",    1'b0, 3'b001, 32'h012, 32'h0,         32'hFFFF_80AD, 1'b0, -1);
      runCheck("lhu_12",   1'b0, 3'b101, 32'h012, 32'h0,         32'h0000_80AD, 1'b0, -1);
      runCheck("lb_11",    1'b0, 3'b000, 32'h011, 32'h0,         32'hFFFF_FFBE, 1'b0, -1);

      runCheck("lh_mis",   1'b0, 3'b001, 32'h011,  32'h0,         32'h0, 1'b1, -1);
      runCheck("sw_oor",   1'b1, 3'b010, 32'h1000, 32'h1111_1111, 32'h0, 1'b1, -1);
      runCheck("lw_mis",   1'b0, 3'b010, 32'h012,  32'h0,         32'h0, 1'b1, -1);
      runCheck("f3_ill",   1'b0, 3'b011, 32'h010,  32'h0,         32'h0, 1'b1, -1);
      runCheck("lw_after", 1'b0, 3'b010, 32'h010,  32'h0,         32'h80AD_BEEF, 1'b0, -1);
      runCheck("sh_12",    1'b1, 3'b001, 32'h012,  32'hABCD_1234, 32'h0, 1'b0, -1);
      runCheck("lw_sh",    1'b0, 3'b010, 32'h010,  32'h0,         32'h1234_BEEF, 1'b0, -1);

      // Response held under backpressure while a competing store is offered.
      sendReq(1'b0, 3'b010, 32'h010, 32'h0, t1);
      waitRsp(lat, rd, er);
      checkOutput("bp_first_rdata", rd, 32'h1234_BEEF);
      reqWrite = 1'b1; reqFunc3 = 3'b010; reqAddr = 32'h010; reqWdata = 32'hFFFF_FFFF; reqValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clock); #1;
         checkOutput("bp_rsp_valid", {31'h0, rspValid1}, 32'h1);
         checkOutput("bp_rdata",     rspRdata1, 32'h1234_BEEF);
         checkOutput("bp_req_ready", {31'h0, reqReady1}, 32'h0);
      end
      reqValid = 1'b0;
      ackRsp();
      checkOutput("bp_released_valid", {31'h0, rspValid1}, 32'h0);
      checkOutput("bp_released_ready", {31'h0, reqReady1}, 32'h1);
      runCheck("bp_no_store", 1'b0, 3'b010, 32'h010, 32'h0, 32'h1234_BEEF, 1'b0, -1);

      // Reset while a store is still waiting to commit.
      runCheck("sw_zero", 1'b1, 3'b010, 32'h020, 32'h0, 32'h0, 1'b0, -1);
      sendReq(1'b1, 3'b010, 32'h020, 32'h1234_5678, t1);
      nReset = 1'b1;
      #1;
      checkOutput("rst_busy_valid", {31'h0, rspValid1}, 32'h0);
      checkOutput("rst_busy_ready", {31'h0, reqReady1}, 32'h1);
      checkOutput("rst_busy_rdata", rspRdata1, 32'h0);
      checkOutput("rst_busy_err",   {31'h0, rspErr1}, 32'h0);
      @(posedge Clock); #1;
      nReset = 1'b0;
      @(posedge Clock); #1;
      runCheck("lw_dropped", 1'b0, 3'b010, 32'h020, 32'h0, 32'h0, 1'b0, 2);

      // Zero-wait-state instance.
      useFast = 1'b1;
      runCheck("fast_sw", 1'b1, 3'b010, 32'h004, 32'hCAFE_F00D, 32'h0,         1'b0, 1);
      runCheck("fast_lw", 1'b0, 3'b010, 32'h004, 32'h0,         32'hCAFE_F00D, 1'b0, 1);
      useFast = 1'b0;

`ifdef DMEM_MMIO_EN
      sendReq(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0, t1);
      waitRsp(lat, rdA, er);
      checkOutput("cyc_a_err", {31'h0, er}, 32'h0);
      ackRsp();
      while ($time < t1 + 91) begin
         @(posedge Clock); #1;
      end
      sendReq(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0, t2);
      waitRsp(lat, rdB, er);
      checkOutput("cyc_b_err", {31'h0, er}, 32'h0);
      ackRsp();
      checkOutput("cyc_delta", rdB - rdA, 32'(((t2 - t1) / 10)));
      checkOutput("cyc_spacing", 32'((t2 - t1) / 10), 32'd10);
      runCheck("scr_sw",  1'b1, 3'b010, 32'hFFFF_FFF4, 32'hA5A5_5A5A, 32'h0,         1'b0, -1);
      runCheck("scr_lw",  1'b0, 3'b010, 32'hFFFF_FFF4, 32'h0,         32'hA5A5_5A5A, 1'b0, -1);
      runCheck("cyc_sw",  1'b1, 3'b010, 32'hFFFF_FFF0, 32'h1,         32'h0,         1'b0, -1);
      runCheck("mmio_lb", 1'b0, 3'b000, 32'hFFFF_FFF4, 32'h0,         32'h0,         1'b1, -1);
      runCheck("mmio_f8", 1'b0, 3'b010, 32'hFFFF_FFF8, 32'h0,         32'h0,         1'b1, -1);
`else
      runCheck("mmio_off",  1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1, -1);
      runCheck("mmio_off4", 1'b1, 3'b010, 32'hFFFF_FFF4, 32'h7, 32'h0, 1'b1, -1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
